ripple_capture_b: RTL and testbench
===================================

// Module: ripple_capture_b
// PURPOSE
//  Downstream consumer of the 6-bit behavioural counter (count, ripple_out).
//  - Extends the counter with a wrap (epoch) count.
//  - Captures {epoch, count} records on counter wrap or on request, into a small FIFO.
//  - Drains the FIFO through a valid/ready port, so software or a later stage reads wrap history without losing events.
// PARAMETERS
//  CNT_W    6   width of count_in; must equal the upstream counter width
//  EPOCH_W  10  width of the wrap counter; wraps modulo 2**EPOCH_W
//  DEPTH    4   FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1                  rising-edge clock, shared with the counter
//  clear      in   1                  synchronous, active-high reset
//  count_in   in   CNT_W              upstream counter value (count)
//  ripple_in  in   1                  upstream ripple_out; level or pulse accepted
//  cap_req    in   1                  one-cycle software capture request
//  out_data   out  EPOCH_W+CNT_W      record {epoch, count}; epoch in MSBs
//  out_valid  out  1                  out_data holds a record
//  out_ready  in   1                  consumer accepts when out_valid & out_ready
//  epoch      out  EPOCH_W            live wrap count
//  level      out  $clog2(DEPTH)+1    FIFO occupancy, 0..DEPTH
//  overflow   out  1                  sticky: an event was dropped while full
// BEHAVIOUR
//  - Reset
//    - clear sampled high at a clk edge sets epoch=0, level=0, out_valid=0, out_data=0, overflow=0.
//    - Same edge: the internal ripple_d loads ripple_in, not 0, so a high ripple_in does not create a false edge after clear.
//    - clear overrides every event, push and pop in that cycle.
//    - Mid-operation clear discards all stored records.
//  - Edge detect
//    - ripple_d <= ripple_in every cycle.
//    - wrap = ripple_in & ~ripple_d.
//    - A held-high ripple_in counts once.
//  - Epoch: on wrap, epoch <= epoch+1, modulo 2**EPOCH_W (1023 -> 0 at default).
//  - Capture event
//    - ev = wrap | cap_req (| match, see CONFIGURATION).
//    - Record = {epoch, count_in}, sampled in the ev cycle, using epoch before that cycle's increment.
//    - Coincident sources in one cycle produce exactly one record.
//  - FIFO
//    - Circular buffer with pointers of $clog2(DEPTH)+1 bits.
//    - pop = out_valid & out_ready.
//    - push = ev & (level<DEPTH | pop); a pop frees its slot for a same-cycle push.
//    - ev while full and no pop: record dropped, overflow <= 1, held until clear.
//    - level updates +push -pop each cycle.
//  - Output timing
//    - Registered, no fall-through: a record pushed into an empty FIFO shows out_valid=1 on the next cycle, i.e. 1-cycle event-to-valid latency.
//    - While out_valid & ~out_ready, out_data and out_valid hold stable.
//    - out_valid = (level != 0). After the last pop, out_valid=0 on the next cycle.
//  - Push plus pop on a 1-entry FIFO: level stays 1, out_data moves to the new record.
// CONFIGURATION
//  - RIPPLE_CAP_MATCH_EN defined:
//    - Adds input match_val [CNT_W-1:0].
//    - match = (count_in==match_val) & ~match_d; match_d is the registered equality, loaded (not zeroed) during clear.
//    - match is ORed into ev and fires once per entry into the match value.
//  - Not defined: no match_val port and no match logic; ev = wrap | cap_req.
// TESTING
//  1. Reset: clear=1 for 2 cycles, with ripple_in=1 held through and after release
//     -> epoch=0, level=0, out_valid=0, overflow=0; no capture occurs after release.
//  2. Wrap capture: count_in=63, ripple_in 0->1 for 1 cycle, out_ready=0
//     -> next cycle out_valid=1, out_data={10'd0,6'd63}, epoch=1, level=1.
//  3. Held level: ripple_in held high 20 cycles -> epoch increments by exactly 1; one record.
//  4. Overflow: DEPTH=4, out_ready=0, 5 cap_req pulses with count_in=1..5
//     -> level=4, overflow=1; drain yields count fields 1,2,3,4 in order.
//  5. Full and simultaneous: FIFO full, cap_req with out_ready=1 in the same cycle
//     -> accepted, level stays 4, overflow stays 0.
//  6. Epoch wrap: 1024 ripple edges -> epoch=0.
//     With RIPPLE_CAP_MATCH_EN, match_val=32 and count_in sweeping 0..63 -> exactly one record {epoch,6'd32} per sweep.

Source files
------------

// File: rtl/ripple_capture_b.sv
// ripple_capture_b: epoch-extends an upstream counter and queues {epoch,count} records.
// Optional macro RIPPLE_CAP_MATCH_EN adds a match_val capture source.
module ripple_capture_b #(
    parameter int CNT_W   = 6,
    parameter int EPOCH_W = 10,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic [CNT_W-1:0]         count_in,
    input  logic                     ripple_in,
    input  logic                     cap_req,
`ifdef RIPPLE_CAP_MATCH_EN
    input  logic [CNT_W-1:0]         match_val,
`endif
    output logic [EPOCH_W+CNT_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EPOCH_W-1:0]       epoch,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = EPOCH_W + CNT_W;

    logic          ripple_d;
    logic          wrap;
    logic          match;
    logic          ev;
    logic          pop;
    logic          push;
    logic          full;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] mem [DEPTH];

`ifdef RIPPLE_CAP_MATCH_EN
    logic match_eq;
    logic match_d;

    assign match_eq = (count_in == match_val);
    assign match    = match_eq & ~match_d;

    // Loaded even during clear so a standing match does not refire on release
    always_ff @(posedge clk) begin
        match_d <= match_eq;
    end
`else
    assign match = 1'b0;
`endif

    assign wrap      = ripple_in & ~ripple_d;
    assign ev        = wrap | cap_req | match;
    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == PW'(DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready & ~clear;
    assign push      = ev & ~clear & (~full | pop);
    assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        ripple_d <= ripple_in;
        if (clear) begin
            epoch    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrap) begin
                epoch <= epoch + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ev & ~push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; out_data is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {epoch, count_in};
        end
    end
endmodule

// File: tb/tb_ripple_capture_b.sv
// tb_ripple_capture_b: directed stimulus against a queue-based model of
// ripple_capture_b, plus literal expectations for the documented scenarios.
module tb_ripple_capture_b;
    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [5:0]  count_in = '0;
    logic        ripple_in = 1'b0;
    logic        cap_req = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  epoch;
    logic [2:0]  level;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    logic [15:0] mq[$];
    int          m_epoch = 0;
    bit          m_ovf   = 1'b0;
    bit          m_prev  = 1'b0;

    ripple_capture_b dut (
        .clk(clk),
        .clear(clear),
        .count_in(count_in),
        .ripple_in(ripple_in),
        .cap_req(cap_req),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .epoch(epoch),
        .level(level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Advance one clock; the model consumes the inputs that were stable at the edge
    task automatic tick();
        bit          w;
        bit          ev;
        logic [15:0] tmp;
        @(posedge clk);
        if (clear) begin
            mq.delete();
            m_epoch = 0;
            m_ovf   = 1'b0;
        end else begin
            w  = ripple_in && !m_prev;
            ev = w || cap_req;
            if (mq.size() != 0 && out_ready)
                tmp = mq.pop_front();
            if (ev) begin
                if (mq.size() < 4)
                    mq.push_back({m_epoch[9:0], count_in});
                else
                    m_ovf = 1'b1;
            end
            if (w)
                m_epoch = (m_epoch + 1) % 1024;
        end
        m_prev = ripple_in;
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("m_level", 32'(level), 32'(mq.size()));
            chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("m_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            chk("m_epoch", 32'(epoch), 32'(m_epoch));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    initial begin
        // Reset with ripple_in high through and after release
        ripple_in = 1'b1;
        clear = 1'b1;
        tick();
        armed = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        chk("rst_epoch", 32'(epoch), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);

        // Wrap capture with 1-cycle latency
        ripple_in = 1'b0;
        tick();
        count_in = 6'd63;
        ripple_in = 1'b1;
        tick();
        chk("wrap_valid", 32'(out_valid), 32'd1);
        chk("wrap_data", 32'(out_data), 32'h003F);
        chk("wrap_epoch", 32'(epoch), 32'd1);
        chk("wrap_level", 32'(level), 32'd1);
        ripple_in = 1'b0;
        count_in = 6'd7;
        tick();
        chk("hold_data", 32'(out_data), 32'h003F);
        out_ready = 1'b1;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Held-high ripple counts once
        out_ready = 1'b0;
        count_in = 6'd10;
        ripple_in = 1'b1;
        repeat (20) tick();
        chk("held_epoch", 32'(epoch), 32'd2);
        chk("held_level", 32'(level), 32'd1);
        chk("held_data", 32'(out_data), 32'h004A);
        ripple_in = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Coincident wrap and cap_req yield one record
        count_in = 6'd5;
        ripple_in = 1'b1;
        cap_req = 1'b1;
        tick();
        chk("coin_level", 32'(level), 32'd1);
        chk("coin_data", 32'(out_data), 32'h0085);
        chk("coin_epoch", 32'(epoch), 32'd3);
        ripple_in = 1'b0;
        cap_req = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Overflow: five requests into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            count_in = 6'(i);
            cap_req = 1'b1;
            tick();
            cap_req = 1'b0;
            tick();
        end
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_order", 32'(out_data), 32'(16'h00C0 + 16'(i)));
            tick();
        end
        chk("ovf_empty", 32'(level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Mid-operation clear discards records and overflow
        out_ready = 1'b0;
        cap_req = 1'b1;
        repeat (2) tick();
        cap_req = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_epoch", 32'(epoch), 32'd0);

        // Full FIFO accepts a push when a pop happens in the same cycle
        for (int i = 11; i <= 14; i++) begin
            count_in = 6'(i);
            cap_req = 1'b1;
            tick();
        end
        chk("full_level", 32'(level), 32'd4);
        count_in = 6'd15;
        out_ready = 1'b1;
        tick();
        cap_req = 1'b0;
        chk("simul_level", 32'(level), 32'd4);
        chk("simul_ovf", 32'(overflow), 32'd0);
        for (int i = 12; i <= 15; i++) begin
            chk("simul_order", 32'(out_data), 32'(i));
            tick();
        end
        chk("simul_empty", 32'(out_valid), 32'd0);

        // Epoch wraps modulo 1024
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ripple_in = 1'b0;
        tick();
        for (int i = 0; i < 1023; i++) begin
            ripple_in = 1'b1;
            tick();
            ripple_in = 1'b0;
            tick();
        end
        chk("ep_1023", 32'(epoch), 32'd1023);
        ripple_in = 1'b1;
        tick();
        chk("ep_wrap", 32'(epoch), 32'd0);
        chk("ep_data", 32'(out_data), 32'hFFC0 | 32'(count_in));
        ripple_in = 1'b0;
        repeat (2) tick();
        chk("ep_ovf", 32'(overflow), 32'd0);

        armed = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
